// File: rtl/adjust_stretch_param.sv
// adjust_stretch_param
//   Frame-buffered linear level stretch. One frame of IMG_W*IMG_H pixels is
//   received and stored while its min (l) and max (h) are tracked. A
//   restoring divider then forms scale = floor(((to-from) << FRAC) / (h-l)).
//   The frame is streamed back remapped from [l,h] to [from,to], with the
//   result saturated to 2^PW-1.
//
//   Ports:
//     clk, xrst            clock, synchronous active-low reset
//     pixel_in, rcv_ack    receive pixel and its strobe
//     rcv_req              block is ready to accept frame pixels
//     pixel_out, snd_ack   processed pixel and its strobe (N consecutive cycles)
//     snd_req              sink request for the processed frame
//     adjust_from_v/to_v   output levels for l / h, latched when CALC is entered
//     h, l                 max / min of the current or last frame
//
//   Build option: define ADJUST_ROUND_EN for round-to-nearest on the final
//   shift; without it the result is truncated.
module adjust_stretch_param #(
  parameter int PW    = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int FRAC  = 8
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic [PW-1:0] pixel_in,
  output logic          rcv_req,
  input  logic          rcv_ack,
  output logic [PW-1:0] pixel_out,
  input  logic          snd_req,
  output logic          snd_ack,
  input  logic [PW-1:0] adjust_from_v,
  input  logic [PW-1:0] adjust_to_v,
  output logic [PW-1:0] h,
  output logic [PW-1:0] l
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + FRAC;
  localparam int MW = 2 * PW + FRAC;
  localparam int CW = $clog2(SW + 1);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
`ifdef ADJUST_ROUND_EN
  localparam logic [MW:0] RND = {{MW{1'b0}}, 1'b1} << (FRAC - 1);
`else
  localparam logic [MW:0] RND = '0;
`endif

  typedef enum logic [1:0] {S_RECV, S_CALC, S_WAIT, S_SEND} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic          rd_done_q, rd_done_d;
  logic          rcv_req_q, rcv_req_d;
  logic [PW-1:0] h_q, h_d, l_q, l_d;
  logic [PW-1:0] from_q, from_d, to_q, to_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [SW-1:0] dvd_q, dvd_d, scale_q, scale_d;
  logic          v1_q, v2_q, v3_q;
  logic [MW-1:0] m_q, m_d;
  logic [PW-1:0] pixel_out_q, pixel_out_d;
  logic [PW-1:0] pix1_q;
  logic [PW-1:0] mem [N];

  logic          wr_en, rd_en;
  logic [PW-1:0] rin, rout;
  logic [PW-1:0] rem_in;
  logic [SW-1:0] dvd_in, dvd_nx;
  logic [PW:0]   rem_sh;
  logic [PW-1:0] d_w;
  logic [MW:0]   q_w, sum_w;

  assign rcv_req   = rcv_req_q;
  assign snd_ack   = v3_q;
  assign pixel_out = pixel_out_q;
  assign h         = h_q;
  assign l         = l_q;

  // Divider step: dvd shifts the dividend out MSB-first and the quotient in
  // LSB-first, so after SW steps it holds the quotient.
  always_comb begin
    rin    = h_q - l_q;
    rout   = (to_q > from_q) ? (to_q - from_q) : '0;
    rem_in = (div_cnt_q == '0) ? '0 : rem_q;
    dvd_in = (div_cnt_q == '0) ? {rout, {FRAC{1'b0}}} : dvd_q;
    rem_sh = {rem_in, dvd_in[SW-1]};
    if (rem_sh >= {1'b0, rin}) begin
      rem_d  = PW'(rem_sh - {1'b0, rin});
      dvd_nx = {dvd_in[SW-2:0], 1'b1};
    end else begin
      rem_d  = rem_sh[PW-1:0];
      dvd_nx = {dvd_in[SW-2:0], 1'b0};
    end
  end

  // Send datapath: stage 2 offset/multiply, stage 3 round/shift/offset/saturate.
  always_comb begin
    d_w         = pix1_q - l_q;
    m_d         = v1_q ? (MW'(d_w) * MW'(scale_q)) : m_q;
    q_w         = ({1'b0, m_q} + RND) >> FRAC;
    sum_w       = q_w + (MW+1)'(from_q);
    pixel_out_d = pixel_out_q;
    if (v2_q)
      pixel_out_d = (sum_w > (MW+1)'({PW{1'b1}})) ? '1 : sum_w[PW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_done_d = rd_done_q;
    rcv_req_d = 1'b0;
    h_d       = h_q;
    l_d       = l_q;
    from_d    = from_q;
    to_d      = to_q;
    div_cnt_d = div_cnt_q;
    dvd_d     = dvd_q;
    scale_d   = scale_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      S_RECV: begin
        rcv_req_d = 1'b1;
        if (rcv_req_q && rcv_ack) begin
          wr_en    = 1'b1;
          wr_cnt_d = (wr_cnt_q == LAST) ? '0 : wr_cnt_q + 1'b1;
          if (wr_cnt_q == '0) begin
            h_d = pixel_in;
            l_d = pixel_in;
          end else begin
            if (pixel_in > h_q) h_d = pixel_in;
            if (pixel_in < l_q) l_d = pixel_in;
          end
          if (wr_cnt_q == LAST) begin
            state_d   = S_CALC;
            rcv_req_d = 1'b0;
            from_d    = adjust_from_v;
            to_d      = adjust_to_v;
            div_cnt_d = '0;
          end
        end
      end
      S_CALC: begin
        if (rin == '0 || rout == '0) begin
          scale_d = '0;
          state_d = S_WAIT;
        end else begin
          dvd_d = dvd_nx;
          if (div_cnt_q == CW'(SW - 1)) begin
            scale_d   = dvd_nx;
            div_cnt_d = '0;
            state_d   = S_WAIT;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (snd_req) begin
          state_d   = S_SEND;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      default: begin
        if (!rd_done_q) begin
          rd_en    = 1'b1;
          rd_cnt_d = (rd_cnt_q == LAST) ? '0 : rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST) rd_done_d = 1'b1;
        end else if (!v1_q && !v2_q && v3_q) begin
          // Last pixel is on the output this cycle; snd_ack drops on this edge.
          state_d = S_RECV;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= pixel_in;
    if (rd_en) pix1_q <= mem[rd_cnt_q];
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q     <= S_RECV;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      rcv_req_q   <= 1'b0;
      h_q         <= '0;
      l_q         <= '1;
      from_q      <= '0;
      to_q        <= '0;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      scale_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      m_q         <= '0;
      pixel_out_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_done_q   <= rd_done_d;
      rcv_req_q   <= rcv_req_d;
      h_q         <= h_d;
      l_q         <= l_d;
      from_q      <= from_d;
      to_q        <= to_d;
      div_cnt_q   <= div_cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      scale_q     <= scale_d;
      v1_q        <= rd_en;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      m_q         <= m_d;
      pixel_out_q <= pixel_out_d;
    end
  end
endmodule

// File: tb/tb_adjust_stretch_param.sv
// Testbench for adjust_stretch_param on a reduced 32x16 frame.
module tb_adjust_stretch_param;
  localparam int W    = 32;
  localparam int HGT  = 16;
  localparam int NPIX = W * HGT;
`ifdef ADJUST_ROUND_EN
  localparam int RND = 128;
  localparam int RP1 = 1;
  localparam int RP3 = 2;
`else
  localparam int RND = 0;
  localparam int RP1 = 0;
  localparam int RP3 = 1;
`endif

  logic       clk = 1'b0;
  logic       xrst;
  logic [7:0] pixel_in;
  logic       rcv_req;
  logic       rcv_ack;
  logic [7:0] pixel_out;
  logic       snd_req;
  logic       snd_ack;
  logic [7:0] adjust_from_v;
  logic [7:0] adjust_to_v;
  logic [7:0] h;
  logic [7:0] l;

  adjust_stretch_param #(.PW(8), .IMG_W(W), .IMG_H(HGT), .FRAC(8)) dut (
    .clk(clk), .xrst(xrst), .pixel_in(pixel_in), .rcv_req(rcv_req),
    .rcv_ack(rcv_ack), .pixel_out(pixel_out), .snd_req(snd_req),
    .snd_ack(snd_ack), .adjust_from_v(adjust_from_v),
    .adjust_to_v(adjust_to_v), .h(h), .l(l)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  int   run_len = 0;
  logic [7:0] frame [NPIX];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_px(input int p, input int lo, input int hi,
                                  input int fr, input int to);
    int rin, rout, scale, q, s;
    rin   = hi - lo;
    rout  = (to > fr) ? to - fr : 0;
    scale = (rin == 0 || rout == 0) ? 0 : (rout * 256) / rin;
    q     = ((p - lo) * scale + RND) / 256;
    s     = fr + q;
    return (s > 255) ? 255 : s;
  endfunction

  // First four expected outputs come from the hand table when >= 0.
  task automatic push_exp(input int lo, input int hi, input int fr,
                          input int to, input int hand[4]);
    int e;
    for (int i = 0; i < NPIX; i++) begin
      e = model_px(int'(frame[i]), lo, hi, fr, to);
      if (i < 4 && hand[i] >= 0) e = hand[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0: frame[i] = (i == 0) ? 8'd20 : (i == 1) ? 8'd220 : (i == 2) ? 8'd120
                      : 8'(20 + (i * 37) % 201);
        1: frame[i] = 8'd77;
        default: frame[i] = 8'(i % 4);
      endcase
    end
  endtask

  task automatic recv_frame(input int stall_every, input int stop_after);
    int cnt = 0, cyc = 0, guard = 0;
    int early = 0;
    while (!rcv_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rcv_req_rise", int'(rcv_req), 1);
    while (cnt < stop_after && cyc < 4 * NPIX) begin
      if (!rcv_req) early = 1;
      rcv_ack  = !(stall_every != 0 && (cyc % stall_every) == stall_every - 1);
      pixel_in = frame[cnt];
      if (rcv_ack && rcv_req) cnt++;
      cyc++;
      @(negedge clk);
    end
    rcv_ack = 1'b0;
    chk("rcv_accept_count", cnt, stop_after);
    chk("rcv_req_held", early, 0);
    if (stop_after == NPIX) chk("rcv_req_fall", int'(rcv_req), 0);
  endtask

  // Called at the negedge right after the last pixel was accepted.
  task automatic do_send(input int calc_len, input int exp_h, input int exp_l,
                         input int poke_adj);
    int k = 0;
    snd_req = 1'b1;
    while (!snd_ack && k < 80) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("h_after_recv", int'(h), exp_h);
        chk("l_after_recv", int'(l), exp_l);
      end
    end
    snd_req = 1'b0;
    chk("snd_ack_latency", k, calc_len + 4);
    if (poke_adj != 0) begin
      adjust_from_v = 8'd7;
      adjust_to_v   = 8'd250;
    end
    k = 0;
    while (snd_ack && k < NPIX + 10) begin
      @(negedge clk);
      k++;
    end
    chk("snd_ack_end", int'(snd_ack), 0);
    chk("rcv_req_after_send", int'(rcv_req), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (snd_ack) begin
      run_len++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pixel_out: got %0d with nothing expected", pixel_out);
      end else begin
        chk("pixel_out", int'(pixel_out), exp_q.pop_front());
      end
    end else if (run_len != 0) begin
      chk("snd_ack_len", run_len, NPIX);
      run_len = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hand1[4]  = '{50, 100, 75, -1};
    int hflat[4]  = '{50, 50, 50, 50};
    int hround[4] = '{0, RP1, 1, RP3};
    int hinv[4]   = '{100, 100, 100, 100};

    xrst = 1'b0; rcv_ack = 1'b0; pixel_in = '0; snd_req = 1'b0;
    adjust_from_v = 8'd50; adjust_to_v = 8'd100;
    repeat (3) @(negedge clk);
    chk("rst_rcv_req", int'(rcv_req), 0);
    chk("rst_snd_ack", int'(snd_ack), 0);
    chk("rst_pixel_out", int'(pixel_out), 0);
    chk("rst_h", int'(h), 0);
    chk("rst_l", int'(l), 255);
    xrst = 1'b1;
    @(negedge clk);
    chk("rcv_req_after_reset", int'(rcv_req), 1);

    // Basic stretch, scale 64.
    fill(0); push_exp(20, 220, 50, 100, hand1);
    recv_frame(0, NPIX); do_send(16, 220, 20, 0);

    // Flat frame: zero input range, single-cycle CALC.
    fill(1); push_exp(77, 77, 50, 100, hflat);
    recv_frame(0, NPIX); do_send(1, 77, 77, 0);

    // Same as first frame with every 5th cycle stalled.
    fill(0); push_exp(20, 220, 50, 100, hand1);
    recv_frame(5, NPIX); do_send(16, 220, 20, 0);

    // Mid-frame reset, then a full frame.
    fill(0);
    recv_frame(0, 200);
    xrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rcv_req", int'(rcv_req), 0);
    chk("mid_rst_snd_ack", int'(snd_ack), 0);
    chk("mid_rst_pixel_out", int'(pixel_out), 0);
    chk("mid_rst_h", int'(h), 0);
    chk("mid_rst_l", int'(l), 255);
    xrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rcv_req_rise", int'(rcv_req), 1);
    push_exp(20, 220, 50, 100, hand1);
    recv_frame(0, NPIX); do_send(16, 220, 20, 0);

    // Rounding: scale 170.
    adjust_from_v = 8'd0; adjust_to_v = 8'd2;
    fill(2); push_exp(0, 3, 0, 2, hround);
    recv_frame(0, NPIX); do_send(16, 3, 0, 0);

    // Inverted range, adjust inputs disturbed during SEND.
    adjust_from_v = 8'd100; adjust_to_v = 8'd50;
    fill(0); push_exp(20, 220, 100, 50, hinv);
    recv_frame(0, NPIX); do_send(1, 220, 20, 1);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adjust_stretch_param.md
# adjust_stretch_param

Parametrised frame-buffered linear level-stretch engine, the next generation of the fixed 128×128/8-bit adjust pipeline. It receives one frame over the req/ack receive port and tracks per-frame minimum `l` and maximum `h`. It then computes a fixed-point scale with a sequential divider and streams the frame back through the send port, remapped from [l,h] to [adjust_from_v, adjust_to_v].

## Interface
- `PW`, 8: pixel width in bits.
- `IMG_W`, 128: frame width in pixels.
- `IMG_H`, 128: frame height in pixels; frame length `N = IMG_W*IMG_H`, address width `$clog2(N)`.
- `FRAC`, 8: fractional bits of the scale factor.
- `clk`  in  1  single clock; all logic rising-edge.
- `xrst`  in  1  synchronous active-low reset.
- `pixel_in`  in  PW  receive data; valid when `rcv_ack`=1.
- `rcv_req`  out  1  block ready to accept frame pixels.
- `rcv_ack`  in  1  one pixel presented this cycle.
- `pixel_out`  out  PW  send data; valid when `snd_ack`=1.
- `snd_req`  in  1  sink requests the processed frame.
- `snd_ack`  out  1  high for exactly N consecutive cycles, one pixel per cycle.
- `adjust_from_v`  in  PW  output level for input `l`.
- `adjust_to_v`  in  PW  output level for input `h`.
- `h`  out  PW  maximum of current/last frame.
- `l`  out  PW  minimum of current/last frame.

## Operation
- States: RECV → CALC → WAIT → SEND → RECV.
- RECV:
  - `rcv_req`=1. Each cycle with `rcv_ack`=1 writes `pixel_in` to the buffer at the write counter and increments the counter.
  - Cycles with `rcv_ack`=0 are stalls: no write, no count.
  - The first accepted pixel loads both `h` and `l`; later pixels update max/min.
  - After pixel N−1 is accepted, go to CALC. `rcv_ack` asserted outside RECV is ignored.
- CALC:
  - On entry, register `from`/`to` from `adjust_from_v`/`adjust_to_v`. Input changes afterwards are ignored until the next CALC.
  - `rin = h−l`; `rout = to−from` if `to>from`, else 0.
  - If `rin`=0 or `rout`=0: scale=0, CALC lasts 1 cycle.
  - Otherwise, a restoring divider computes `scale = floor((rout<<FRAC)/rin)` in PW+FRAC cycles, width PW+FRAC bits.
- WAIT: holds until `snd_req`=1 is sampled.
- SEND: 3-stage pipeline.
  - Stage 1: buffer read.
  - Stage 2: `d=p−l`; `m=d*scale` (2PW+FRAC bits).
  - Stage 3: `q=(m+R)>>FRAC`; `pixel_out=min(from+q, 2^PW−1)`.
  - `R` is defined under Configuration.
  - No backpressure: the sink must take one pixel per cycle while `snd_ack`=1.
- After the last pixel is sent, go to RECV. The buffer read/write counters wrap to 0 at N.

## Timing
- Reset values: `rcv_req`=0, `snd_ack`=0, `pixel_out`=0, `h`=0, `l`=2^PW−1; state RECV, counters 0.
- Reset during any state aborts the frame; the next frame restarts at pixel 0.
- `rcv_req` rises on the first edge after `xrst` goes high, and on the edge after SEND ends.
- `rcv_req` falls on the edge that accepts pixel N−1.
- `snd_req` sampled at edge E → `snd_ack` rises at edge E+3, with pixel 0 on `pixel_out` in that cycle.
- `snd_ack` falls at E+3+N. `snd_req` may deassert any time after E.
- `h`/`l` are stable from CALC entry until the first pixel of the next frame.
- Frame period with no stalls or wait: N + CALC(1 or PW+FRAC) + 3 + N cycles, plus 1 cycle to re-raise `rcv_req`.

## Configuration
- `ADJUST_ROUND_EN` defined: `R = 2^(FRAC−1)`, round-to-nearest.
- `ADJUST_ROUND_EN` undefined: `R = 0`, truncation.
- Saturation is present in both builds.

## Test plan
- Defaults, frame values in [20,220] with min 20 and max 220, from=50, to=100 (scale=64):
  - 20→50, 220→100, 120→75.
  - `h`=220, `l`=20.
  - `snd_ack` high exactly 16384 cycles, starting 3 cycles after `snd_req` is sampled.
- Flat frame, all pixels 77 → `h`=`l`=77, CALC 1 cycle, every output = 50.
- Same frame as the first test with `rcv_ack` deasserted on every 5th cycle → output identical to the first test; `rcv_req` falls only after the 16384th accepted pixel.
- `xrst` low for 1 cycle after 1000 pixels accepted:
  - All outputs return to reset values; `rcv_req` is high on the next cycle.
  - A full new frame then processes correctly.
- Rounding: l=0, h=3, from=0, to=2 (scale=170):
  - Pixel 1 → 1 with `ADJUST_ROUND_EN`, 0 without.
  - Pixel 2 → 1 in both builds.
- from=100, to=50 → all outputs 100; `adjust_*` changed during SEND → no effect on the current frame.
